gpio_reg_arbiter: RTL and testbench

Shares the single-master GPIO register port (write enable, 32-bit address, write data, read data) between several independent requesters, such as the CPU bus bridge, a debug/test master and a pin-pattern sequencer. It performs round-robin arbitration with at most one access per cycle and returns read data one cycle after grant. It also provides a bus lock so one requester can do an atomic read-modify-write, for example read `direct_out`, then write it back. It sits directly in front of the GPIO register interface.

---
 rtl/gpio_pkg.sv | 13 +
 rtl/gpio_rr_arb.sv | 32 +++
 rtl/gpio_reg_arbiter.sv | 93 +++++++++
 tb/tb_gpio_reg_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared GPIO register-port widths, request struct and arbiter state encoding
package gpio_pkg;
    localparam int unsigned NumGpioReq = 4;
    localparam int unsigned GpioRegAw = 32;
    localparam int unsigned GpioRegDw = 32;
    typedef struct packed {
        logic                 we;
        logic [GpioRegAw-1:0] addr;
        logic [GpioRegDw-1:0] wdata;
        logic                 lock;
    } gpio_reg_req_t;
    typedef enum logic {ArbUnlocked, ArbLocked} gpio_arb_state_e;
endpackage

// File: rtl/gpio_rr_arb.sv
// gpio_rr_arb: stateless round-robin picker, first masked request at or above ptr, wrapping
module gpio_rr_arb #(
    parameter int unsigned NumReq = 4,
    localparam int unsigned IdxW = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    input  logic [NumReq-1:0] mask_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              vld_o
);
    logic [NumReq-1:0] eff;
    assign eff = req_i & mask_i;
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (eff[i] && i < int'(ptr_i)) begin
                idx_o = IdxW'(i);
                vld_o = 1'b1;
            end
        end
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (eff[i] && i >= int'(ptr_i)) begin
                idx_o = IdxW'(i);
                vld_o = 1'b1;
            end
        end
    end
    assign gnt_o = vld_o ? (NumReq'(1) << idx_o) : '0;
endmodule

// File: rtl/gpio_reg_arbiter.sv
// gpio_reg_arbiter: round-robin sharing of the GPIO register port with a timed bus lock
module gpio_reg_arbiter
    import gpio_pkg::*;
#(
    parameter int unsigned NumReq = NumGpioReq,
    parameter int unsigned LockTimeout = 255,
    localparam int unsigned IdxW = $clog2(NumReq)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumReq-1:0]                   req_i,
    input  logic [NumReq-1:0]                   we_i,
    input  logic [NumReq-1:0][GpioRegAw-1:0]    addr_i,
    input  logic [NumReq-1:0][GpioRegDw-1:0]    wdata_i,
    input  logic [NumReq-1:0]                   lock_i,
    output logic [NumReq-1:0]                   gnt_o,
    output logic [NumReq-1:0]                   rvalid_o,
    output logic [GpioRegDw-1:0]                rdata_o,
    output logic                                locked_o,
    output logic [IdxW-1:0]                     lock_owner_o,
    output logic                                lock_timeout_o,
    output logic                                reg_we_o,
    output logic [GpioRegAw-1:0]                reg_addr_o,
    output logic [GpioRegDw-1:0]                reg_wdata_o,
    input  logic [GpioRegDw-1:0]                reg_rdata_i
);
    gpio_arb_state_e state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d, owner_q, owner_d, idx;
    logic [15:0] cnt_q, cnt_d;
    logic [NumReq-1:0] mask;
    logic run_q, vld, tmo;
    gpio_reg_req_t sel;
    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] v);
        return (32'(v) == NumReq - 1) ? '0 : v + 1'b1;
    endfunction
    assign mask = (state_q == ArbLocked) ? (NumReq'(1) << owner_q) : '1;
    gpio_rr_arb #(.NumReq(NumReq)) u_arb (
        .req_i  (req_i & {NumReq{run_q}}),
        .ptr_i  (ptr_q),
        .mask_i (mask),
        .gnt_o  (gnt_o),
        .idx_o  (idx),
        .vld_o  (vld)
    );
    always_comb begin
        sel = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt_o[i]) sel = '{we: we_i[i], addr: addr_i[i], wdata: wdata_i[i], lock: lock_i[i]};
        end
    end
    assign reg_we_o = sel.we;
    assign reg_addr_o = sel.addr;
    assign reg_wdata_o = sel.wdata;
    assign tmo = (state_q == ArbLocked) && !vld && (32'(cnt_q) + 32'd1 >= LockTimeout);
    assign lock_timeout_o = tmo;
    assign locked_o = (state_q == ArbLocked);
    assign lock_owner_o = locked_o ? owner_q : '0;
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (vld) begin
            state_d = sel.lock ? ArbLocked : ArbUnlocked;
            owner_d = idx;
            ptr_d = wrap_inc(idx);
            cnt_d = '0;
        end else if (state_q == ArbLocked) begin
            state_d = tmo ? ArbUnlocked : ArbLocked;
            ptr_d = tmo ? wrap_inc(owner_q) : ptr_q;
            cnt_d = tmo ? '0 : cnt_q + 16'd1;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= 1'b0;
            state_q <= ArbUnlocked;
            owner_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
            rvalid_o <= '0;
            rdata_o <= '0;
        end else begin
            run_q <= 1'b1;
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            rvalid_o <= gnt_o;
            rdata_o <= (vld && !sel.we) ? reg_rdata_i : '0;
        end
    end
endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// tb_gpio_reg_arbiter: directed stimulus with a per-cycle behavioural model and literal anchors
module tb_gpio_reg_arbiter;
    localparam int N = 4;
    localparam int LT = 4;
    logic clk = 1'b0;
    logic rst_ni;
    logic [N-1:0] req, we, lock;
    logic [N-1:0][31:0] addr, wdata;
    logic [N-1:0] gnt, rvalid;
    logic [31:0] rdata, reg_addr, reg_wdata, reg_rdata;
    logic locked, tmo, reg_we;
    logic [1:0] owner;
    int tests = 0;
    int fails = 0;
    int m_ptr, m_owner, m_idle, m_rv;
    logic m_run, m_locked;
    logic [31:0] m_rd;
    always #5 clk = ~clk;
    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return 32'hA5A5_0001 + a;
    endfunction
    assign reg_rdata = rd_of(reg_addr);
    gpio_reg_arbiter #(.NumReq(N), .LockTimeout(LT)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .lock_i(lock), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .locked_o(locked), .lock_owner_o(owner), .lock_timeout_o(tmo), .reg_we_o(reg_we),
        .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask
    // Who the spec says wins right now: first eligible requester scanning from ptr, wrapping.
    function automatic int exp_gnt();
        int r = -1;
        if (m_run)
            for (int k = N - 1; k >= 0; k--)
                if (req[(m_ptr + k) % N] && (!m_locked || (m_ptr + k) % N == m_owner)) r = (m_ptr + k) % N;
        return r;
    endfunction
    function automatic logic [31:0] onehot(input int i);
        return (i < 0) ? 32'd0 : (32'd1 << i);
    endfunction
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_run <= 1'b0; m_locked <= 1'b0; m_ptr <= 0; m_owner <= 0; m_idle <= 0;
            m_rv <= -1; m_rd <= '0;
        end else begin
            m_run <= 1'b1;
            m_rv <= exp_gnt();
            m_rd <= (exp_gnt() >= 0 && !we[exp_gnt()]) ? rd_of(addr[exp_gnt()]) : 32'd0;
            if (exp_gnt() >= 0) begin
                m_ptr <= (exp_gnt() + 1) % N;
                m_idle <= 0;
                m_locked <= lock[exp_gnt()];
                m_owner <= exp_gnt();
            end else if (m_locked) begin
                if (m_idle + 1 == LT) begin
                    m_locked <= 1'b0;
                    m_idle <= 0;
                    m_ptr <= (m_owner + 1) % N;
                end else m_idle <= m_idle + 1;
            end
        end
    end
    always @(negedge clk) begin
        chk("gnt", 32'(gnt), onehot(exp_gnt()));
        chk("rvalid", 32'(rvalid), onehot(m_rv));
        chk("rdata", rdata, m_rd);
        chk("locked", 32'(locked), 32'(m_locked));
        chk("owner", 32'(owner), m_locked ? 32'(m_owner) : 32'd0);
        chk("timeout", 32'(tmo), 32'(m_run && m_locked && exp_gnt() < 0 && m_idle + 1 == LT));
        chk("reg_we", 32'(reg_we), exp_gnt() < 0 ? 32'd0 : 32'(we[exp_gnt()]));
        chk("reg_addr", reg_addr, exp_gnt() < 0 ? 32'd0 : addr[exp_gnt()]);
        chk("reg_wdata", reg_wdata, exp_gnt() < 0 ? 32'd0 : wdata[exp_gnt()]);
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic neg();
        @(negedge clk);
    endtask
    task automatic put(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, input logic l);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; lock[i] = l;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        rst_ni = 1'b0; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        repeat (3) cyc();
        neg(); chk("lit_rst_gnt", 32'(gnt), 32'd0); chk("lit_rst_locked", 32'(locked), 32'd0);
        cyc(); rst_ni = 1'b1;
        for (int i = 0; i < N; i++) put(i, 1'b0, 32'(i * 4), 32'd0, 1'b0);
        neg(); chk("lit_first_gnt_gated", 32'(gnt), 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(); neg();
            chk("lit_rr_gnt", 32'(gnt), 32'd1 << (k % 4));
            chk("lit_rr_rvalid", 32'(rvalid), k == 0 ? 32'd0 : 32'd1 << ((k - 1) % 4));
        end
        cyc(); req = '0; put(1, 1'b0, 32'h0, 32'h0, 1'b0);
        neg(); chk("lit_rd_gnt", 32'(gnt), 32'b0010);
        cyc(); req[1] = 1'b0; put(0, 1'b1, 32'h4, 32'hFFFF_1234, 1'b0);
        neg(); chk("lit_rd_rvalid", 32'(rvalid), 32'b0010); chk("lit_rd_rdata", rdata, 32'hA5A5_0001);
        chk("lit_wr_we", 32'(reg_we), 32'd1); chk("lit_wr_addr", reg_addr, 32'h4);
        chk("lit_wr_wdata", reg_wdata, 32'hFFFF_1234); chk("lit_wr_gnt", 32'(gnt), 32'b0001);
        cyc(); req[0] = 1'b0;
        neg(); chk("lit_wr_rvalid", 32'(rvalid), 32'b0001); chk("lit_wr_rdata", rdata, 32'd0);
        cyc(); put(0, 1'b0, 32'h10, 32'h0, 1'b0); put(3, 1'b0, 32'h14, 32'h0, 1'b0); put(2, 1'b0, 32'h0, 32'h0, 1'b1);
        neg(); chk("lit_rmw_rd_gnt", 32'(gnt), 32'b0100);
        cyc(); put(2, 1'b1, 32'h8, 32'h5A, 1'b0);
        neg(); chk("lit_rmw_locked", 32'(locked), 32'd1); chk("lit_rmw_owner", 32'(owner), 32'd2);
        chk("lit_rmw_wr_gnt", 32'(gnt), 32'b0100);
        cyc(); req[2] = 1'b0;
        neg(); chk("lit_rmw_unlocked", 32'(locked), 32'd0); chk("lit_rmw_next", 32'(gnt), 32'b1000);
        cyc(); req[3] = 1'b0;
        neg(); chk("lit_rmw_after", 32'(gnt), 32'b0001);
        cyc(); req[0] = 1'b0; put(1, 1'b0, 32'h20, 32'h0, 1'b1); put(0, 1'b0, 32'h24, 32'h0, 1'b0);
        neg(); chk("lit_to_lock_gnt", 32'(gnt), 32'b0010);
        for (int k = 1; k <= 4; k++) begin
            cyc(); if (k == 1) req[1] = 1'b0;
            neg(); chk("lit_to_pulse", 32'(tmo), 32'(k == 4)); chk("lit_to_stall", 32'(gnt), 32'd0);
        end
        cyc(); neg();
        chk("lit_to_next_gnt", 32'(gnt), 32'b0001); chk("lit_to_once", 32'(tmo), 32'd0);
        cyc(); req[0] = 1'b0; put(2, 1'b0, 32'h30, 32'h0, 1'b1);
        neg(); chk("lit_own_lock_gnt", 32'(gnt), 32'b0100);
        for (int k = 1; k <= 3; k++) begin
            cyc(); if (k == 1) req[2] = 1'b0;
            neg();
        end
        cyc(); put(2, 1'b0, 32'h34, 32'h0, 1'b0);
        neg(); chk("lit_own_wins_gnt", 32'(gnt), 32'b0100); chk("lit_own_no_to", 32'(tmo), 32'd0);
        cyc(); req[2] = 1'b0;
        neg(); chk("lit_own_unlocked", 32'(locked), 32'd0); chk("lit_own_rdata", rdata, 32'hA5A5_0035);
        cyc(); put(1, 1'b0, 32'h40, 32'h0, 1'b1);
        neg(); chk("lit_rl_gnt", 32'(gnt), 32'b0010);
        cyc(); put(1, 1'b0, 32'h44, 32'h0, 1'b1);
        neg(); chk("lit_rl_locked", 32'(locked), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("lit_rl_gnt0", 32'(gnt), 32'd0); chk("lit_rl_rvalid0", 32'(rvalid), 32'd0);
        chk("lit_rl_rdata0", rdata, 32'd0); chk("lit_rl_locked0", 32'(locked), 32'd0);
        chk("lit_rl_owner0", 32'(owner), 32'd0); chk("lit_rl_to0", 32'(tmo), 32'd0);
        chk("lit_rl_we0", 32'(reg_we), 32'd0); chk("lit_rl_addr0", reg_addr, 32'd0);
        chk("lit_rl_wdata0", reg_wdata, 32'd0);
        req[1] = 1'b0; put(3, 1'b0, 32'h48, 32'h0, 1'b0);
        cyc(); neg(); chk("lit_rl_no_rvalid", 32'(rvalid), 32'd0);
        cyc(); rst_ni = 1'b1;
        neg(); chk("lit_rl_gated", 32'(gnt), 32'd0);
        cyc(); neg(); chk("lit_rl_req3", 32'(gnt), 32'b1000);
        cyc(); req[3] = 1'b0;
        neg(); chk("lit_rl_rvalid3", 32'(rvalid), 32'b1000); chk("lit_rl_rdata3", rdata, 32'hA5A5_0049);
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
